// File: rtl/seg_pkg.sv
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants, shadow-register layout and the hex to
//               7-segment table used by the display path and counter blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam logic [7:0] SEG_OFF    = 8'hFF;  // all segments dark (active low)
  localparam logic [3:0] AN_OFF     = 4'hF;   // all anodes off (active low)
  localparam int         NUM_DIGITS = 4;

  // Frame-stable copy of the producer's digit word
  typedef struct packed {
    logic [15:0] dig;  // four hex nibbles, nibble 0 = rightmost digit
    logic [3:0]  en;   // per-digit enable
    logic [3:0]  dp;   // per-digit decimal point, 1 = lit
  } shadow_t;

  // Hex nibble to active-low segments, bit order g..a
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;  // F
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_hex_decode.sv
// ============================================================================
// Module      : seg_hex_decode
// Description : Combinational nibble + decimal point to active-low 8-bit
//               segment pattern {dp, g..a}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_hex_decode (
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);
  import seg_pkg::*;

  // dp is active low on the bus, so a lit point drives bit 7 low
  always_comb begin
    o_seg = {~i_dp, hex_to_seg(i_nibble)};
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_mux.sv
// ============================================================================
// Module      : seg_scan_mux
// Description : Time-multiplexes four hex digits onto a shared active-low
//               7-segment bus. A 16-bit digit word is captured into shadow
//               registers only at a frame boundary (upd/updAck handshake),
//               so a displayed frame is never torn.
// Options     : SEG_GHOST_BLANK_EN - blank the first BLANK_CYCLES cycles of
//               every digit slot to suppress ghosting on anode switch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_mux #(
  parameter int SCAN_DIV     = 16,  // cycles per digit slot, >= 2
  parameter int BLANK_CYCLES = 2    // dark cycles per slot when blanking enabled
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  digEn,
  input  logic [3:0]  dpMask,
  input  logic        upd,
  output logic        updAck,
  output logic        frameStart,
  output logic [7:0]  seg,
  output logic [3:0]  an
);
  import seg_pkg::*;

  localparam int                 c_cnt_w   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(SCAN_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_idx;
  shadow_t            r_shadow;
  logic               r_upd_ack;
  logic               r_frame_start;
  logic               r_boot;

  logic               w_wrap;
  logic               w_boundary;
  logic [3:0]         w_nib;
  logic               w_en;
  logic               w_dp;
  logic               w_blank;
  logic [7:0]         w_seg_dec;

  assign w_wrap     = (r_cnt == c_cnt_max);
  assign w_boundary = w_wrap && (r_idx == 2'd3);

  // Prescaler and digit index: slot advances when the prescaler wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame-boundary capture of the producer word plus ack/frame pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow      <= '0;
      r_upd_ack     <= 1'b0;
      r_frame_start <= 1'b0;
      r_boot        <= 1'b1;
    end else begin
      r_boot        <= 1'b0;
      r_frame_start <= w_boundary;
      r_upd_ack     <= w_boundary && upd;
      if (w_boundary && upd) begin
        r_shadow <= '{dig: digits, en: digEn, dp: dpMask};
      end
    end
  end

  // The first slot after reset release has no preceding boundary edge, so
  // r_boot stands in for the frame pulse until the first clock edge.
  assign frameStart = r_frame_start | (r_boot & rst_n);
  assign updAck     = r_upd_ack;

  assign w_nib = r_shadow.dig[{r_idx, 2'b00} +: 4];
  assign w_en  = r_shadow.en[r_idx];
  assign w_dp  = r_shadow.dp[r_idx];

  seg_hex_decode u_dec (
    .i_nibble (w_nib),
    .i_dp     (w_dp),
    .o_seg    (w_seg_dec)
  );

`ifdef SEG_GHOST_BLANK_EN
  localparam logic [c_cnt_w-1:0] c_blank = c_cnt_w'(BLANK_CYCLES);
  assign w_blank = (r_cnt < c_blank);
`else
  assign w_blank = 1'b0;
`endif

  // Bus drive from registered state only; dark when digit disabled or blanked
  always_comb begin
    an  = AN_OFF;
    seg = SEG_OFF;
    if (w_en && !w_blank) begin
      an  = ~(4'b0001 << r_idx);
      seg = w_seg_dec;
    end
  end

endmodule

`default_nettype wire
